// File: rtl/ram_read_mux.sv
// Multi-bank RAM read-data selector: tracks each read strobe through a
// configurable bank latency and returns the selected word with a valid pulse.
module ram_read_mux #(
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int SEL_W     = 2,
  parameter int READ_LAT  = 1,
  parameter int HOLD_LAST = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          read_strobe_i,
  input  logic [SEL_W-1:0]              ram_sel_i,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_data_i,
  output logic [DATA_W-1:0]             data_in_o,
  output logic                          data_valid_o,
  output logic                          sel_err_o,
  output logic                          busy_o,
  output logic [15:0]                   rd_count_o
);

  localparam logic [SEL_W:0] NumBanksL = (SEL_W+1)'(NUM_BANKS);

  if (NUM_BANKS > (1 << SEL_W)) begin : g_chk_sel
    $error("ram_read_mux: NUM_BANKS does not fit in SEL_W select bits");
  end
  if (READ_LAT < 0 || READ_LAT > 4) begin : g_chk_lat
    $error("ram_read_mux: READ_LAT must lie in 0..4");
  end

  logic             retValid;
  logic [SEL_W-1:0] retSel;
  logic             pipeBusy;

  // With zero latency the request bypasses the pipeline and returns on the strobe edge.
  if (READ_LAT == 0) begin : g_nolat
    assign retValid = read_strobe_i;
    assign retSel   = ram_sel_i;
    assign pipeBusy = 1'b0;
  end else begin : g_pipe
    logic [READ_LAT-1:0] valid_q, valid_d;
    logic [SEL_W-1:0]    sel_q [READ_LAT];
    logic [SEL_W-1:0]    sel_d [READ_LAT];

    always_comb begin
      valid_d[0] = read_strobe_i;
      sel_d[0]   = ram_sel_i;
      for (int k = 1; k < READ_LAT; k++) begin
        valid_d[k] = valid_q[k-1];
        sel_d[k]   = sel_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int k = 0; k < READ_LAT; k++) sel_q[k] <= '0;
      end else begin
        valid_q <= valid_d;
        for (int k = 0; k < READ_LAT; k++) sel_q[k] <= sel_d[k];
      end
    end

    assign retValid = valid_q[READ_LAT-1];
    assign retSel   = sel_q[READ_LAT-1];
    assign pipeBusy = |valid_q;
  end

  logic [DATA_W-1:0] bankWord;
  logic              selOutOfRange;

  always_comb begin
    bankWord = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (retSel == SEL_W'(k)) bankWord = bank_data_i[k*DATA_W +: DATA_W];
    end
  end

  assign selOutOfRange = ({1'b0, retSel} >= NumBanksL);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [15:0]       count_q, count_d;

  always_comb begin
    data_d  = (HOLD_LAST != 0) ? data_q : '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    count_d = count_q;
    if (retValid) begin
      valid_d = 1'b1;
      err_d   = selOutOfRange;
      data_d  = selOutOfRange ? '0 : bankWord;
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign data_in_o    = data_q;
  assign data_valid_o = valid_q;
  assign sel_err_o    = err_q;
  assign rd_count_o   = count_q;
  assign busy_o       = read_strobe_i | pipeBusy;

endmodule

// File: tb/tb_ram_read_mux.sv
// Randomized bench for ram_read_mux: three configurations share one stimulus
// stream and are compared against a per-cycle history reference model.
module tb_ram_read_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [2:0]  selBus;
  logic [63:0] bankBus;

  logic [7:0]  dataO  [3];
  logic        validO [3];
  logic        errO   [3];
  logic        busyO  [3];
  logic [15:0] countO [3];

  int lat  [3] = '{2, 0, 1};
  int nb   [3] = '{3, 4, 5};
  int hold [3] = '{0, 1, 0};
  int mask [3] = '{3, 3, 7};

  logic       histStrobe [8];
  logic [2:0] histSel    [8];
  int         cyc;

  logic [7:0]  expData  [3];
  logic        expValid [3];
  logic        expErr   [3];
  logic [15:0] expCount [3];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  ram_read_mux #(.DATA_W(8), .NUM_BANKS(3), .SEL_W(2), .READ_LAT(2), .HOLD_LAST(0)) dutA (
    .clk(clk), .rst_n(rst_n), .read_strobe_i(strobe), .ram_sel_i(selBus[1:0]),
    .bank_data_i(bankBus[23:0]), .data_in_o(dataO[0]), .data_valid_o(validO[0]),
    .sel_err_o(errO[0]), .busy_o(busyO[0]), .rd_count_o(countO[0]));

  ram_read_mux #(.DATA_W(8), .NUM_BANKS(4), .SEL_W(2), .READ_LAT(0), .HOLD_LAST(1)) dutB (
    .clk(clk), .rst_n(rst_n), .read_strobe_i(strobe), .ram_sel_i(selBus[1:0]),
    .bank_data_i(bankBus[31:0]), .data_in_o(dataO[1]), .data_valid_o(validO[1]),
    .sel_err_o(errO[1]), .busy_o(busyO[1]), .rd_count_o(countO[1]));

  ram_read_mux #(.DATA_W(8), .NUM_BANKS(5), .SEL_W(3), .READ_LAT(1), .HOLD_LAST(0)) dutC (
    .clk(clk), .rst_n(rst_n), .read_strobe_i(strobe), .ram_sel_i(selBus),
    .bank_data_i(bankBus[39:0]), .data_in_o(dataO[2]), .data_valid_o(validO[2]),
    .sel_err_o(errO[2]), .busy_o(busyO[2]), .rd_count_o(countO[2]));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cyc);
    else
      passCount++;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) begin
      histStrobe[i] = 1'b0;
      histSel[i]    = '0;
    end
    for (int d = 0; d < 3; d++) begin
      expData[d]  = '0;
      expValid[d] = 1'b0;
      expErr[d]   = 1'b0;
      expCount[d] = '0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("%s_data%0d", tag, d), 32'(dataO[d]), 32'h0);
      checkOutput($sformatf("%s_valid%0d", tag, d), 32'(validO[d]), 32'h0);
      checkOutput($sformatf("%s_err%0d", tag, d), 32'(errO[d]), 32'h0);
      checkOutput($sformatf("%s_count%0d", tag, d), 32'(countO[d]), 32'h0);
      checkOutput($sformatf("%s_busy%0d", tag, d), 32'(busyO[d]), 32'h0);
    end
  endtask

  // One cycle: drive inputs, check busy mid-cycle, advance the model at the edge, check outputs.
  task automatic applyStimulus(input logic s, input logic [2:0] sl, input logic [63:0] banks);
    logic expBusy;
    int   idx;
    int   sv;
    @(negedge clk);
    strobe  = s;
    selBus  = sl;
    bankBus = banks;
    histStrobe[cyc % 8] = s;
    histSel[cyc % 8]    = sl;
    #1;
    for (int d = 0; d < 3; d++) begin
      expBusy = s;
      for (int k = 1; k <= lat[d]; k++) expBusy = expBusy | histStrobe[(cyc - k) % 8];
      checkOutput($sformatf("busy%0d", d), 32'(busyO[d]), 32'(expBusy));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      idx = (cyc - lat[d]) % 8;
      if (histStrobe[idx]) begin
        sv = int'(histSel[idx]) & mask[d];
        expValid[d] = 1'b1;
        expErr[d]   = (sv >= nb[d]);
        expData[d]  = (sv >= nb[d]) ? 8'h00 : bankBus[sv*8 +: 8];
        expCount[d] = expCount[d] + 16'd1;
      end else begin
        expValid[d] = 1'b0;
        expErr[d]   = 1'b0;
        if (hold[d] == 0) expData[d] = 8'h00;
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("data%0d", d), 32'(dataO[d]), 32'(expData[d]));
      checkOutput($sformatf("valid%0d", d), 32'(validO[d]), 32'(expValid[d]));
      checkOutput($sformatf("err%0d", d), 32'(errO[d]), 32'(expErr[d]));
      checkOutput($sformatf("count%0d", d), 32'(countO[d]), 32'(expCount[d]));
    end
    cyc++;
  endtask

  // Asynchronous reset a few ns after an edge; outputs must clear before the next edge.
  task automatic doReset(input int holdCycles);
    #2;
    rst_n  = 1'b0;
    strobe = 1'b0;
    #1;
    checkAllZero("rst");
    repeat (holdCycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  initial begin
    rst_n   = 1'b0;
    strobe  = 1'b0;
    selBus  = '0;
    bankBus = '0;
    cyc     = 8;
    clearModel();
    #1;
    checkAllZero("init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 3'd0, 64'h0);
    applyStimulus(1'b1, 3'd2, 64'h5A_0000);
    repeat (4) applyStimulus(1'b0, 3'd0, 64'h5A_0000);

    applyStimulus(1'b1, 3'd0, 64'h0055_4433_2211);
    applyStimulus(1'b1, 3'd3, 64'h0055_4433_2211);
    applyStimulus(1'b1, 3'd1, 64'h0055_4433_2211);
    applyStimulus(1'b1, 3'd4, 64'h0055_4433_2211);
    repeat (3) applyStimulus(1'b0, 3'd0, 64'h0055_4433_2211);

    applyStimulus(1'b1, 3'd1, 64'hC300);
    repeat (5) applyStimulus(1'b0, 3'd0, 64'h0);

    applyStimulus(1'b1, 3'd1, 64'h7700);
    doReset(1);
    repeat (4) applyStimulus(1'b0, 3'd1, 64'h7777);

    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), 3'($urandom), {$urandom, $urandom});
      if (i == 250) doReset(2);
    end

    for (int i = 0; i < 65540; i++)
      applyStimulus(1'b1, 3'($urandom), {$urandom, $urandom});
    repeat (6) applyStimulus(1'b0, 3'($urandom), {$urandom, $urandom});

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
